vga_draw_arbiter: RTL

// Downstream of the ball/paddle/score draw FSMs; sole owner of the VGA adapter plot port.

---
 rtl/vga_draw_pkg.sv | 21 ++
 rtl/vga_draw_arbiter_rr_priority_pick.sv | 35 +++
 rtl/vga_draw_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vga_draw_pkg.sv
// Shared types and geometry for the VGA draw arbiter.
// Client indices follow the draw FSMs that sit upstream.
package vga_draw_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  localparam int CL_BALL   = 0;
  localparam int CL_PADDLE = 1;
  localparam int CL_SCORE  = 2;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    RELEASE
  } state_e;

endpackage

// File: rtl/vga_draw_arbiter_rr_priority_pick.sv
// Round-robin pick: first eligible request at or above the
// pointer, wrapping back to index 0.
module rr_priority_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_eligible,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  winner,
  output logic          any_valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, pointer} + (PW+1)'(k);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (req_eligible[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end

  assign any_valid = |req_eligible;

endmodule

// File: rtl/vga_draw_arbiter.sv
// Frame-buffer plot port arbiter: round-robin grant with a
// hold watchdog, registered pixel path and off-screen clipping.
module vga_draw_arbiter #(
  parameter int N_CLIENTS = 3,
  parameter int X_W       = vga_draw_pkg::X_W,
  parameter int Y_W       = vga_draw_pkg::Y_W,
  parameter int C_W       = vga_draw_pkg::C_W,
  parameter int X_MAX     = vga_draw_pkg::X_MAX,
  parameter int Y_MAX     = vga_draw_pkg::Y_MAX,
  parameter int HOLD_MAX  = 1024
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CLIENTS-1:0]     req,
  input  logic [N_CLIENTS-1:0]     wr,
  input  logic [N_CLIENTS*X_W-1:0] x_in,
  input  logic [N_CLIENTS*Y_W-1:0] y_in,
  input  logic [N_CLIENTS*C_W-1:0] c_in,
  output logic [N_CLIENTS-1:0]     gnt,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [C_W-1:0]           vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic [7:0]               clip_cnt
);

  import vga_draw_pkg::*;

  localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);

  state_e state_q, state_d;

  logic [PW-1:0]        ptr_q, owner_q, win_idx, ptr_next;
  logic [N_CLIENTS-1:0] mask_q, eligible, winner;
  logic                 any_valid;
  logic [HW-1:0]        hold_q;
  logic                 own_req, timeout;
  logic                 grant_now, end_own, set_mask;
  logic                 accept, in_range;
  logic [X_W-1:0]       x_sel;
  logic [Y_W-1:0]       y_sel;
  logic [C_W-1:0]       c_sel;

  assign eligible = req & ~mask_q;

  rr_priority_pick #(
    .N  (N_CLIENTS),
    .PW (PW)
  ) u_pick (
    .req_eligible (eligible),
    .pointer      (ptr_q),
    .winner       (winner),
    .any_valid    (any_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      if (winner[i])
        win_idx = PW'(i);
  end

  assign own_req  = req[owner_q];
  assign timeout  = own_req && (hold_q == HW'(HOLD_MAX - 1));
  assign ptr_next = (owner_q == PW'(N_CLIENTS - 1))
                  ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = OWN;
      OWN:     if (!own_req || timeout) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_now = (state_q == IDLE) && any_valid;
    end_own   = (state_q == OWN) && (!own_req || timeout);
    set_mask  = (state_q == OWN) && timeout;
    busy      = (state_q == OWN) || (state_q == RELEASE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt     <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      mask_q  <= '0;
      hold_q  <= '0;
    end else begin
      mask_q <= (mask_q & req) | (set_mask ? gnt : '0);
      if (grant_now) begin
        gnt     <= winner;
        owner_q <= win_idx;
        hold_q  <= '0;
      end else if (end_own) begin
        gnt   <= '0;
        ptr_q <= ptr_next;
      end else if (state_q == OWN) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  // gnt is only non-zero in OWN, so it doubles as the accept gate.
  assign accept   = |(gnt & wr);
  assign x_sel    = x_in[owner_q*X_W +: X_W];
  assign y_sel    = y_in[owner_q*Y_W +: Y_W];
  assign c_sel    = c_in[owner_q*C_W +: C_W];
  assign in_range = (x_sel <= X_W'(X_MAX))
                 && (y_sel <= Y_W'(Y_MAX));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      clip_cnt   <= '0;
    end else begin
      vga_plot <= accept && in_range;
      if (accept && in_range) begin
        vga_x      <= x_sel;
        vga_y      <= y_sel;
        vga_colour <= c_sel;
      end
      if (accept && !in_range && clip_cnt != 8'hFF)
        clip_cnt <= clip_cnt + 1'b1;
    end
  end

endmodule
